axi_sm_s00_regs: RTL and testbench
==================================

AXI_SM_S00_REGS -- requirements
Module: axi_sm_s00_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width covering 4 registers.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 s00_axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-005 s00_axi_areset  in  1  synchronous active-high reset.
REQ-006 s00_axi_awaddr  in  4  write address; awprot in 3, ignored.
REQ-007 s00_axi_awvalid in 1 / s00_axi_awready out 1  write address handshake.
REQ-008 s00_axi_wdata in 32 / s00_axi_wstrb in 4  write data and byte enables.
REQ-009 s00_axi_wvalid in 1 / s00_axi_wready out 1  write data handshake.
REQ-010 s00_axi_bresp out 2 / s00_axi_bvalid out 1 / s00_axi_bready in 1  write response.
REQ-011 s00_axi_araddr in 4 / arprot in 3 (ignored) / s00_axi_arvalid in 1 / s00_axi_arready out 1  read address.
REQ-012 s00_axi_rdata out 32 / s00_axi_rresp out 2 / s00_axi_rvalid out 1 / s00_axi_rready in 1  read data.
REQ-013 reg_q  out  128  current register contents, reg0 in bits [31:0] through reg3 in [127:96].
REQ-014 wr_pulse  out  4  one-hot, high one cycle when register i is written.

Function
REQ-015 Register index SHALL be addr[3:2]; addr[1:0] ignored; all 4 indices valid.
REQ-016 AW and W SHALL be accepted independently and in either order; each is held in an internal holding flag until its partner arrives.
REQ-017 awready SHALL be 1 iff no AW held, bvalid=0 and reset low; wready likewise with W held.
REQ-018 A write SHALL commit on the edge where both AW and W are available (held or handshaking that cycle).
REQ-019 Write commit SHALL update each byte b of the selected register only where wstrb[b]=1.
REQ-020 On commit, bvalid SHALL rise the next cycle with bresp=2'b00; holding flags clear on the same edge.
REQ-021 bvalid SHALL stay high until bvalid&&bready; no new AW/W is accepted while bvalid=1.
REQ-022 wr_pulse[idx] SHALL be high for exactly the cycle in which bvalid first rises.
REQ-023 arready SHALL be 1 iff rvalid=0 and reset low.
REQ-024 On ar handshake, rdata SHALL latch the selected register and rvalid rises the next cycle; rresp=2'b00.
REQ-025 rvalid and rdata SHALL hold stable until rvalid&&rready; rdata is 0 when rvalid=0.
REQ-026 A read and a write commit to the same register on the same edge SHALL return the pre-write value.
REQ-027 Read and write channels SHALL operate concurrently with no mutual stall.
REQ-028 Minimum write throughput SHALL be one write per 2 cycles with bready tied high; read likewise.

Reset
REQ-029 While reset high, all outputs SHALL be 0, including all readies, bvalid, rvalid, reg_q and wr_pulse.
REQ-030 awready, wready and arready SHALL be 1 in the first cycle after reset deasserts.
REQ-031 Reset mid-transaction SHALL drop held AW/W, bvalid and rvalid with no partial register write.

Verification
REQ-032 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back the same addresses -> rdata 0x1,0x2,0x3,0x4, all resp OKAY.
REQ-033 W valid 3 cycles before AW at 0x8 data 0x55 -> wready drops after the W handshake; bvalid rises 1 cycle after the AW handshake; reg2=0x55.
REQ-034 reg1=0x00000002, write 0x4 data 0xAABBCCDD wstrb 4'b0010 -> reg1=0x0000CC02; wr_pulse=4'b0010 for one cycle.
REQ-035 bready held low 5 cycles after a write -> bvalid stays 1, awready/wready stay 0, and a second AW is not accepted until the B handshake.
REQ-036 Write 0x9 to reg3 (old 0x4) committing on the same edge as an AR handshake for 0xC -> rdata=0x4; a subsequent read returns 0x9.
REQ-037 Assert reset while bvalid=1 -> bvalid=0 and reg_q=0 during reset; all readies are 1 in the first cycle after release.

Source files
------------

// File: rtl/axi_sm_s00_regs.sv
// AXI4-Lite slave exposing four 32-bit registers.
// Register contents are also driven out in parallel with per-register write pulses.
module axi_sm_s00_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_q,
  output logic [3:0]                        wr_pulse
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;

  logic          aw_held;
  logic          w_held;
  logic [1:0]    aw_idx_q;
  logic [DW-1:0] wdata_q;
  logic [NB-1:0] wstrb_q;
  logic          bvalid_q;
  logic [3:0]    pulse_q;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] regs [4];

  logic          aw_hs;
  logic          w_hs;
  logic          ar_hs;
  logic          commit;
  logic [1:0]    wr_idx;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_strb;
  logic          unused;

  assign unused = ^{s00_axi_awprot, s00_axi_arprot,
                    s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign s00_axi_awready = !s00_axi_areset && !aw_held && !bvalid_q;
  assign s00_axi_wready  = !s00_axi_areset && !w_held && !bvalid_q;
  assign s00_axi_arready = !s00_axi_areset && !rvalid_q;

  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_hs  = s00_axi_wvalid && s00_axi_wready;
  assign ar_hs = s00_axi_arvalid && s00_axi_arready;

  // A held beat stands in for its live channel once accepted
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_idx  = aw_held ? aw_idx_q : s00_axi_awaddr[3:2];
  assign wr_data = w_held ? wdata_q : s00_axi_wdata;
  assign wr_strb = w_held ? wstrb_q : s00_axi_wstrb;

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      pulse_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      pulse_q <= '0;
      if (commit) begin
        for (int b = 0; b < NB; b++)
          if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        bvalid_q        <= 1'b1;
        aw_held         <= 1'b0;
        w_held          <= 1'b0;
        pulse_q[wr_idx] <= 1'b1;
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_idx_q <= s00_axi_awaddr[3:2];
        end
        if (w_hs) begin
          w_held  <= 1'b1;
          wdata_q <= s00_axi_wdata;
          wstrb_q <= s00_axi_wstrb;
        end
      end
      if (bvalid_q && s00_axi_bready) bvalid_q <= 1'b0;
      // Reads sample before this edge's write lands
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= regs[s00_axi_araddr[3:2]];
      end else if (rvalid_q && s00_axi_rready) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end
    end
  end

  assign s00_axi_bresp  = 2'b00;
  assign s00_axi_rresp  = 2'b00;
  assign s00_axi_bvalid = !s00_axi_areset && bvalid_q;
  assign s00_axi_rvalid = !s00_axi_areset && rvalid_q;
  assign s00_axi_rdata  = s00_axi_areset ? '0 : rdata_q;
  assign wr_pulse       = s00_axi_areset ? '0 : pulse_q;

  for (genvar i = 0; i < 4; i++) begin : g_regq
    assign reg_q[i*DW +: DW] = s00_axi_areset ? '0 : regs[i];
  end

endmodule

// File: tb/tb_axi_sm_s00_regs.sv
// Testbench for axi_sm_s00_regs.
// Read data is checked through an expected-value queue.
module tb_axi_sm_s00_regs;

  logic         clk = 1'b0;
  logic         areset = 1'b1;
  logic [3:0]   awaddr = '0;
  logic [2:0]   awprot = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b1;
  logic [3:0]   araddr = '0;
  logic [2:0]   arprot = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b1;
  logic [127:0] reg_q;
  logic [3:0]   wr_pulse;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [31:0] model [4];
  logic [31:0] exp_q [$];

  axi_sm_s00_regs dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (areset),
    .s00_axi_awaddr (awaddr),
    .s00_axi_awprot (awprot),
    .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata  (wdata),
    .s00_axi_wstrb  (wstrb),
    .s00_axi_wvalid (wvalid),
    .s00_axi_wready (wready),
    .s00_axi_bresp  (bresp),
    .s00_axi_bvalid (bvalid),
    .s00_axi_bready (bready),
    .s00_axi_araddr (araddr),
    .s00_axi_arprot (arprot),
    .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata  (rdata),
    .s00_axi_rresp  (rresp),
    .s00_axi_rvalid (rvalid),
    .s00_axi_rready (rready),
    .reg_q          (reg_q),
    .wr_pulse       (wr_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    bit ad = 0;
    bit wd = 0;
    int n = 0;
    logic a_s, w_s;
    logic [3:0] oh;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (!(ad && wd) && n < 20) begin
      a_s = awvalid && awready;
      w_s = wvalid && wready;
      step();
      if (a_s) begin ad = 1; awvalid = 1'b0; end
      if (w_s) begin wd = 1; wvalid = 1'b0; end
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin step(); n++; end
    n_cmp++;
    if (bvalid !== 1'b1) begin
      n_err++;
      $display("FAIL write_bvalid a=%h: got %b expected 1", a, bvalid);
    end else begin
      oh = 4'(1) << a[3:2];
      n_cmp++;
      if (bresp !== 2'b00) begin
        n_err++;
        $display("FAIL write_bresp: got %b expected 00", bresp);
      end
      n_cmp++;
      if (wr_pulse !== oh) begin
        n_err++;
        $display("FAIL wr_pulse_on: got %b expected %b", wr_pulse, oh);
      end
      for (int b = 0; b < 4; b++)
        if (s[b]) model[a[3:2]][8*b +: 8] = d[8*b +: 8];
      step();
      n_cmp++;
      if (wr_pulse !== 4'b0000) begin
        n_err++;
        $display("FAIL wr_pulse_off: got %b expected 0000", wr_pulse);
      end
    end
  endtask

  task automatic axi_read(input logic [3:0] a);
    int n = 0;
    logic [31:0] e;
    exp_q.push_back(model[a[3:2]]);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    while (!arready && n < 20) begin step(); n++; end
    step();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin step(); n++; end
    e = exp_q.pop_front();
    n_cmp++;
    if (rvalid !== 1'b1) begin
      n_err++;
      $display("FAIL read_timeout a=%h: rvalid %b expected 1", a, rvalid);
    end else begin
      if (rdata !== e || rresp !== 2'b00) begin
        n_err++;
        $display("FAIL read a=%h: got %h/%b expected %h/00", a, rdata, rresp, e);
      end
      step();
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    step(); step();
    n_cmp++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp,
         rdata, reg_q, wr_pulse} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got nonzero expected all zero");
    end
    areset = 1'b0;
    #1;
    n_cmp++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_err++;
      $display("FAIL reset_release: got %b expected 111", {awready, wready, arready});
    end
    for (int i = 0; i < 4; i++) model[i] = '0;
  endtask

  task automatic test_write_read();
    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h4, 32'h2, 4'hF);
    axi_write(4'h8, 32'h3, 4'hF);
    axi_write(4'hC, 32'h4, 4'hF);
    axi_read(4'h0);
    axi_read(4'h4);
    axi_read(4'h8);
    axi_read(4'hC);
    n_cmp++;
    if (rdata !== 32'h0) begin
      n_err++;
      $display("FAIL rdata_idle: got %h expected 0", rdata);
    end
  endtask

  task automatic test_w_before_aw();
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
    awaddr = 4'h8; awvalid = 1'b0;
    step();
    wvalid = 1'b0;
    n_cmp++;
    if (wready !== 1'b0) begin
      n_err++;
      $display("FAIL wready_held: got %b expected 0", wready);
    end
    step(); step();
    awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b1 || wr_pulse !== 4'b0100) begin
      n_err++;
      $display("FAIL w_first_b: got %b/%b expected 1/0100", bvalid, wr_pulse);
    end
    model[2] = 32'h55;
    step();
    n_cmp++;
    if (reg_q[95:64] !== 32'h55 || bvalid !== 1'b0) begin
      n_err++;
      $display("FAIL w_first_reg2: got %h/%b expected 00000055/0", reg_q[95:64], bvalid);
    end
  endtask

  task automatic test_wstrb();
    axi_write(4'h4, 32'hAABBCCDD, 4'b0010);
    n_cmp++;
    if (reg_q[63:32] !== 32'h0000CC02) begin
      n_err++;
      $display("FAIL wstrb_reg1: got %h expected 0000cc02", reg_q[63:32]);
    end
  endtask

  task automatic test_bready_stall();
    awaddr = 4'h0; wdata = 32'h77; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    step();
    wvalid = 1'b0;
    awaddr = 4'h4;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({bvalid, awready, wready} !== 3'b100) begin
        n_err++;
        $display("FAIL stall_%0d: got %b expected 100", i, {bvalid, awready, wready});
      end
      step();
    end
    model[0] = 32'h77;
    bready = 1'b1;
    step();
    n_cmp++;
    if ({bvalid, awready} !== 2'b01) begin
      n_err++;
      $display("FAIL stall_release: got %b expected 01", {bvalid, awready});
    end
    wdata = 32'h66; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    model[1] = 32'h66;
    n_cmp++;
    if (bvalid !== 1'b1 || reg_q[63:32] !== 32'h66 || reg_q[31:0] !== 32'h77) begin
      n_err++;
      $display("FAIL stall_second: got %b/%h/%h expected 1/66/77",
               bvalid, reg_q[63:32], reg_q[31:0]);
    end
    step();
  endtask

  task automatic test_collision();
    logic [31:0] e;
    exp_q.push_back(model[3]);
    awaddr = 4'hC; wdata = 32'h9; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'hC; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model[3] = 32'h9;
    e = exp_q.pop_front();
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== e) begin
      n_err++;
      $display("FAIL collision_old: got %b/%h expected 1/%h", rvalid, rdata, e);
    end
    step();
    axi_read(4'hC);
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cyc;
    axi_write(4'h0, 32'h11111111, 4'hF);
    axi_write(4'h4, 32'h22222222, 4'hF);
    axi_write(4'h8, 32'h33333333, 4'hF);
    axi_write(4'hC, 32'h44444444, 4'hF);
    n_cmp++;
    if (cyc - c0 > 8) begin
      n_err++;
      $display("FAIL wr_throughput: got %0d cycles expected <= 8", cyc - c0);
    end
    c0 = cyc;
    axi_read(4'h0);
    axi_read(4'h4);
    axi_read(4'h8);
    axi_read(4'hC);
    n_cmp++;
    if (cyc - c0 > 8) begin
      n_err++;
      $display("FAIL rd_throughput: got %0d cycles expected <= 8", cyc - c0);
    end
  endtask

  task automatic test_reset_mid();
    awaddr = 4'h8; wdata = 32'hDEAD; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_bvalid: got %b expected 1", bvalid);
    end
    areset = 1'b1;
    #1;
    n_cmp++;
    if (bvalid !== 1'b0 || reg_q !== '0) begin
      n_err++;
      $display("FAIL mid_reset_out: got %b/%h expected 0/0", bvalid, reg_q);
    end
    step();
    n_cmp++;
    if ({awready, wready, arready, bvalid, reg_q} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_hold: got nonzero expected 0");
    end
    areset = 1'b0;
    bready = 1'b1;
    #1;
    n_cmp++;
    if ({awready, wready, arready, bvalid} !== 4'b1110) begin
      n_err++;
      $display("FAIL mid_release: got %b expected 1110",
               {awready, wready, arready, bvalid});
    end
    for (int i = 0; i < 4; i++) model[i] = '0;
    step();
    axi_read(4'h8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_w_before_aw();
    test_wstrb();
    test_bready_stall();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
